instr_encode: RTL and testbench

//  Streaming RV32/RV64-base instruction encoder, the inverse of the decode stage.

---
 rtl/instr_encode_pkg.sv | 59 +++++
 rtl/instr_encode_fmt.sv | 50 +++++
 rtl/instr_encode.sv | 124 ++++++++++++
 tb/tb_instr_encode.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_pkg.sv
// Shared definitions for the instruction encoder.
//   OP_*      : RV32/RV64 base opcodes recognised by the encoder
//   fmt_e     : instruction format class (3 bits)
//   enc_req_t : decoded field set presented to the encoder
//   op_fmt    : opcode -> format classification
//   sfits     : true when v is representable as a 'bits'-wide signed value
package instr_encode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP32   = 7'h3B;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SYS, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [11:0] csr_addr;
  } enc_req_t;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    case (op)
      OP_OP, OP_OP32:                       return FMT_R;
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32:   return FMT_I;
      OP_SYSTEM:                            return FMT_SYS;
      OP_STORE:                             return FMT_S;
      OP_BRANCH:                            return FMT_B;
      OP_LUI, OP_AUIPC:                     return FMT_U;
      OP_JAL:                               return FMT_J;
      default:                              return FMT_BAD;
    endcase
  endfunction

  // All bits above the sign bit must replicate it.
  function automatic logic sfits(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/instr_encode_fmt.sv
// Combinational opcode classify + field pack + immediate range check.
//   req      in  : decoded field set
//   fmt      out : format class (FMT_BAD for unknown opcode)
//   ins      out : packed 32-bit instruction word (0 for FMT_BAD)
//   range_ok out : immediate fits its format; constant 1 unless the
//                  IMM_RANGE_CHECK_EN macro is defined
module instr_encode_fmt
  import instr_encode_pkg::*;
(
  input  enc_req_t    req,
  output fmt_e        fmt,
  output logic [31:0] ins,
  output logic        range_ok
);

  always_comb begin
    fmt = op_fmt(req.opcode);
    ins = '0;
    case (fmt)
      FMT_R:   ins = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I:   ins = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_SYS: ins = {req.csr_addr, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S:   ins = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                      req.opcode};
      FMT_B:   ins = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                      req.imm[4:1], req.imm[11], req.opcode};
      FMT_U:   ins = {req.imm[31:12], req.rd, req.opcode};
      FMT_J:   ins = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                      req.rd, req.opcode};
      default: ins = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = sfits(req.imm, 12);
      FMT_B:        range_ok = sfits(req.imm, 13) && !req.imm[0];
      FMT_J:        range_ok = sfits(req.imm, 21) && !req.imm[0];
      FMT_U:        range_ok = (req.imm[11:0] == 12'h000);
      default:      range_ok = 1'b1;
    endcase
  end
`else
  // Out-of-range immediates are silently truncated to the format fields.
  assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encode.sv
// Streaming instruction encoder: decoded fields in, 32-bit words plus
// sequential byte addresses out.
//   clk, rst_n          : clock, async active-low reset
//   start, base_addr    : load address counter (bits [1:0] forced 0), clear count
//   in_valid/in_ready   : field-set handshake (in_ready = !full)
//   opcode..csr_addr    : decoded fields
//   out_valid/out_ready : word handshake; out_ins/out_addr word and its address
//   err_op, err_range   : sticky error flags, cleared by err_clr (set wins)
//   count               : words emitted since last start, saturating
// Optional: IMM_RANGE_CHECK_EN enables immediate range checking/err_range.
module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  input  logic [11:0]       csr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_op,
  output logic              err_range,
  input  logic              err_clr,
  output logic [15:0]       count
);

  localparam int PW = $clog2(DEPTH);

  enc_req_t    req;
  fmt_e        fmt;
  logic [31:0] enc_ins;
  logic        range_ok;

  assign req = '{opcode: opcode, funct3: funct3, funct7: funct7, rs1: rs1,
                 rs2: rs2, rd: rd, imm: imm, csr_addr: csr_addr};

  instr_encode_fmt u_fmt (
    .req      (req),
    .fmt      (fmt),
    .ins      (enc_ins),
    .range_ok (range_ok)
  );

  // FIFO of {ins, addr}; pointers carry one extra wrap bit for full/empty.
  logic [DEPTH-1:0][31:0]       mem_ins;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [PW:0]                  wr_ptr, rd_ptr;
  logic                         full, empty;
  logic [ADDR_W-1:0]            counter, cur_addr;
  logic                         accept, emit, good, bad_op;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready = !full;
  assign out_valid = !empty;
  assign out_ins  = mem_ins[rd_ptr[PW-1:0]];
  assign out_addr = mem_addr[rd_ptr[PW-1:0]];

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;
  assign bad_op = accept && (fmt == FMT_BAD);
  assign good   = accept && (fmt != FMT_BAD) && range_ok;

  // A start in the accept cycle binds the new base to that very word.
  assign cur_addr = start ? (base_addr & ~ADDR_W'(3)) : counter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ins  <= '0;
      mem_addr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      counter  <= '0;
    end else begin
      counter <= good ? cur_addr + ADDR_W'(4) : cur_addr;
      if (good) begin
        mem_ins[wr_ptr[PW-1:0]]  <= enc_ins;
        mem_addr[wr_ptr[PW-1:0]] <= cur_addr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (emit) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (start)                   count <= '0;
    else if (emit && count != 16'hFFFF) count <= count + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_op <= 1'b0;
    else if (bad_op)  err_op <= 1'b1;
    else if (err_clr) err_op <= 1'b0;
  end

`ifdef IMM_RANGE_CHECK_EN
  logic bad_rng;
  assign bad_rng = accept && (fmt != FMT_BAD) && !range_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_range <= 1'b0;
    else if (bad_rng) err_range <= 1'b1;
    else if (err_clr) err_range <= 1'b0;
  end
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: known encodings, backpressure, error
// flags, start/count interactions, address wrap, B-type round trip and
// reset while full. Expectations follow IMM_RANGE_CHECK_EN when defined.
module tb_instr_encode;
  import instr_encode_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0, in_ready;
  logic [6:0]        opcode = '0, funct7 = '0;
  logic [2:0]        funct3 = '0;
  logic [4:0]        rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0]       imm = '0;
  logic [11:0]       csr_addr = '0;
  logic              out_valid, out_ready = 1'b0;
  logic [31:0]       out_ins;
  logic [ADDR_W-1:0] out_addr;
  logic              err_op, err_range, err_clr = 1'b0;
  logic [15:0]       count;

  int n_tests = 0, n_fail = 0;

  instr_encode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .csr_addr(csr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_addr(out_addr), .err_op(err_op), .err_range(err_range),
    .err_clr(err_clr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_f(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic [31:0] im, input logic [11:0] csr);
    opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = d;
    imm = im; csr_addr = csr;
  endtask

  // Present one field set, wait (bounded) for in_ready, return #1 after accept edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [31:0] im, input logic [11:0] csr);
    int t;
    @(negedge clk);
    set_f(op, f3, f7, r1, r2, d, im, csr);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a word, capture it, consume it.
  task automatic pop_raw(output logic [31:0] w, output logic [ADDR_W-1:0] a);
    int t;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("pop_timeout", 1, 0);
    w = out_ins; a = out_addr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] ei, input logic [ADDR_W-1:0] ea);
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    pop_raw(w, a);
    chk({tag, "_ins"}, w, ei);
    chk({tag, "_addr"}, a, ea);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    int acc;
    logic [ADDR_W-1:0] nxt;
    logic [31:0] w, bimm, dimm;
    logic [ADDR_W-1:0] a;
    logic [4:0] r1, r2;
    logic [2:0] f3;
    logic [11:0] h;
    logic [2:0] f3_tab [6];
    f3_tab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ins", out_ins, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_op", err_op, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_count", count, 0);
    @(negedge clk); rst_n = 1'b1;

    do_start(32'h100);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 12'd0);
    chk("lat1_valid", out_valid, 1);
    pop("addi", 32'h00500093, 32'h100);
    send(OP_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 12'd0);
    pop("lui", 32'h123452B7, 32'h104);
    send(OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 12'd0);
    pop("jal", 32'h008000EF, 32'h108);
    send(OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 12'd0);
    pop("beq", 32'hFE208EE3, 32'h10C);
    send(OP_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 12'd0);
    pop("sw", 32'h0020A423, 32'h110);
    send(OP_OP, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 12'd0);
    pop("sub", 32'h402081B3, 32'h114);
    send(OP_SYSTEM, 3'd1, 7'd0, 5'd6, 5'd0, 5'd5, 32'd0, 12'h300);
    pop("csrrw", 32'h300312F3, 32'h118);
    chk("count7", count, 7);

    // Backpressure: in_valid held, out_ready low.
    @(negedge clk);
    set_f(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0, 12'd0);
    in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      logic r;
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin acc++; imm = 32'(acc); end
    end
    in_valid = 1'b0;
    chk("fill_acc", acc, DEPTH);
    chk("fill_ready", in_ready, 0);
    pop("drain0", 32'h00000093, 32'h11C);
    pop("drain1", 32'h00100093, 32'h120);

    // Unknown opcode: dropped, address reused.
    send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0, 12'd0);
    chk("badop_err", err_op, 1);
    chk("badop_novalid", out_valid, 0);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd7, 12'd0);
    pop("after_bad", 32'h00700093, 32'h124);
    pulse_clr();
    chk("errclr", err_op, 0);
    @(negedge clk);
    set_f(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0, 12'd0);
    in_valid = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0;
    chk("set_wins", err_op, 1);
    pulse_clr();

    // Immediate out of 12-bit range.
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048, 12'd0);
`ifdef IMM_RANGE_CHECK_EN
    chk("imm2048_err", err_range, 1);
    chk("imm2048_drop", out_valid, 0);
    nxt = 32'h128;
    pulse_clr();
`else
    pop("imm2048", 32'h80000093, 32'h128);
    chk("imm2048_err", err_range, 0);
    nxt = 32'h12C;
`endif

    // start keeps buffered words and their addresses; base bits [1:0] dropped.
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd9, 12'd0);
    do_start(32'h203);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd3, 12'd0);
    pop("keep", 32'h00900093, nxt);
    pop("newbase", 32'h00300093, 32'h200);
    chk("count_after_start", count, 2);

    // start in the accept cycle.
    @(negedge clk);
    start = 1'b1; base_addr = 32'h400;
    set_f(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd4, 12'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 12'd0);
    pop("st_acc0", 32'h00400093, 32'h400);
    pop("st_acc1", 32'h00500093, 32'h404);

    // start in the emit cycle: count cleared.
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd6, 12'd0);
    @(negedge clk);
    start = 1'b1; base_addr = 32'h500; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk("start_wins_count", count, 0);
    chk("emit_done", out_valid, 0);

    // Address wrap.
    do_start(32'hFFFF_FFFC);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 12'd0);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2, 12'd0);
    pop("wrap0", 32'h00100093, 32'hFFFF_FFFC);
    pop("wrap1", 32'h00200093, 32'h0);

    // B-type round trip through an independent decode.
    for (int i = 0; i < 6; i++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      f3 = f3_tab[i];
      h = 12'($urandom);
      bimm = {{19{h[11]}}, h, 1'b0};
      send(OP_BRANCH, f3, 7'd0, r1, r2, 5'd0, bimm, 12'd0);
      pop_raw(w, a);
      dimm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      chk("rt_fields", {w[6:0], w[14:12], w[19:15], w[24:20]}, {OP_BRANCH, f3, r1, r2});
      chk("rt_imm", dimm, bimm);
    end

    // Reset asserted while the buffer is full.
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 12'd0);
    send(OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2, 12'd0);
    chk("full_before_rst", in_ready, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_ready", in_ready, 1);
    chk("rst_full_count", count, 0);
    chk("rst_full_addr", out_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
